// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 master issuing one 2*DATA_W-bit frame (command byte then data
// byte, MSB first) per accepted start, capturing MISO across the whole frame.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   start_i      transaction request, sampled only while idle
//   tx_cmd_i     command byte, latched on an accepted start
//   tx_data_i    data byte, latched on an accepted start
//   miso_i       serial data from the peripheral
//   loopback_i   (SPI_HOST_MASTER_LOOPBACK_EN only) rx samples internal mosi when set
//   sclk_o       SPI clock, idles low
//   mosi_o       serial data to the peripheral
//   cs_o         chip select, active low
//   busy_o       high from start acceptance until done
//   done_o       one-cycle pulse in the first idle cycle after a frame
//   rx_data_o    last DATA_W bits received, held until the next done
//
// Optional feature macro: SPI_HOST_MASTER_LOOPBACK_EN
module spi_host_master #(
   parameter int unsigned CLK_DIV  = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_HOLD  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_cmd_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              miso_i,
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
   input  logic              loopback_i,
`endif
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              cs_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o
);

   localparam int unsigned FrameW = 2 * DATA_W;
   localparam int unsigned CntMax = (CLK_DIV > CS_SETUP) ?
                                    ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                                    ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam int unsigned CntW   = $clog2(CntMax);
   localparam int unsigned BitW   = $clog2(FrameW);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [BitW-1:0]     bit_q, bit_d;
   logic [FrameW-1:0]   tx_q, tx_d;
   // Only the final DATA_W received bits are ever observable, so rx keeps just those.
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                sclk_q, sclk_d;
   logic                cs_q, cs_d;
   logic                done_q, done_d;
   logic                rx_bit;

   // mosi is the tx MSB directly; the last fall does not shift, so the final bit is held.
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
   logic                lb_q, lb_d;
   assign rx_bit = lb_q ? tx_q[FrameW-1] : miso_i;
`else
   assign rx_bit = miso_i;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      done_d    = 1'b0;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
      lb_d      = lb_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               tx_d    = {tx_cmd_i, tx_data_i};
               cs_d    = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StSetup;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
               lb_d    = loopback_i;
`endif
            end
         end
         StSetup: begin
            if (cnt_q == CntW'(CS_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = StShift;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StShift: begin
            if (cnt_q == CntW'(CLK_DIV - 1)) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_d = {rx_q[DATA_W-2:0], rx_bit};
               end else if (bit_q == BitW'(FrameW - 1)) begin
                  state_d = StHold;
               end else begin
                  tx_d  = {tx_q[FrameW-2:0], 1'b0};
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == CntW'(CS_HOLD - 1)) begin
               cnt_d     = '0;
               cs_d      = 1'b1;
               rx_data_d = rx_q;
               done_d    = 1'b1;
               state_d   = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         done_q    <= 1'b0;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
         lb_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         done_q    <= done_d;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
         lb_q      <= lb_d;
`endif
      end
   end

   assign sclk_o    = sclk_q;
   assign mosi_o    = tx_q[FrameW-1];
   assign cs_o      = cs_q;
   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed bench for spi_host_master with CLK_DIV=2, CS_SETUP=2, CS_HOLD=2.
// A small MISO model shifts out a 16-bit pattern, one bit per sclk rise; a monitor records
// mosi at each sclk rise and counts cs-low cycles, done pulses and sclk-while-cs-high.
module tb_spi_host_master;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       start_i;
   logic [7:0] tx_cmd_i;
   logic [7:0] tx_data_i;
   logic       miso_i;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
   logic       loopback_i;
`endif
   logic       sclk_o;
   logic       mosi_o;
   logic       cs_o;
   logic       busy_o;
   logic       done_o;
   logic [7:0] rx_data_o;

   int          vectors     = 0;
   int          miscompares = 0;

   // Monitor state (written only by the monitor process).
   logic        sclk_prev   = 1'b0;
   logic [15:0] mosi_cap    = '0;
   int          rise_tot    = 0;
   int          frame_rises = 0;
   int          cs_low_tot  = 0;
   int          done_tot    = 0;
   int          glitch_tot  = 0;

   logic [15:0] miso_pat    = '0;
   int          snap_cs;
   int          snap_done;
   int          snap_rise;
   int          n;

   always #5 clk_i = ~clk_i;

   spi_host_master #(
      .CLK_DIV (2),
      .DATA_W  (8),
      .CS_SETUP(2),
      .CS_HOLD (2)
   ) u_dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .tx_cmd_i  (tx_cmd_i),
      .tx_data_i (tx_data_i),
      .miso_i    (miso_i),
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
      .loopback_i(loopback_i),
`endif
      .sclk_o    (sclk_o),
      .mosi_o    (mosi_o),
      .cs_o      (cs_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .rx_data_o (rx_data_o)
   );

   // Peripheral model: bit (15 - rises so far in this frame) is presented before each rise.
   assign miso_i = miso_pat[4'(15 - frame_rises)];

   always @(posedge clk_i) begin
      #2;
      if (sclk_o === 1'b1 && sclk_prev === 1'b0) begin
         mosi_cap = {mosi_cap[14:0], mosi_o};
         rise_tot++;
         frame_rises++;
      end
      if (cs_o === 1'b1) frame_rises = 0;
      if (cs_o === 1'b0) cs_low_tot++;
      if (done_o === 1'b1) done_tot++;
      if (cs_o === 1'b1 && sclk_o === 1'b1) glitch_tot++;
      sclk_prev = sclk_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      @(negedge clk_i);
      while (done_o !== 1'b1 && k < 300) begin
         @(negedge clk_i);
         k++;
      end
      check(tag, {31'd0, done_o}, 32'd1);
   endtask

   initial begin
      rst_ni    = 1'b0;
      start_i   = 1'b0;
      tx_cmd_i  = 8'h00;
      tx_data_i = 8'h00;
`ifdef SPI_HOST_MASTER_LOOPBACK_EN
      loopback_i = 1'b0;
`endif
      repeat (3) @(negedge clk_i);

      // Reset state
      check("rst_cs",   {31'd0, cs_o},   32'd1);
      check("rst_sclk", {31'd0, sclk_o}, 32'd0);
      check("rst_mosi", {31'd0, mosi_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_rx",   {24'd0, rx_data_o}, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Frame 1: cmd 0x01, data 0xA5
      miso_pat  = 16'h00A5;
      tx_cmd_i  = 8'h01;
      tx_data_i = 8'hA5;
      snap_cs   = cs_low_tot;
      snap_rise = rise_tot;
      snap_done = done_tot;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i   = 1'b0;
      check("f1_cs_low",  {31'd0, cs_o},   32'd0);
      check("f1_busy",    {31'd0, busy_o}, 32'd1);
      check("f1_mosi0",   {31'd0, mosi_o}, 32'd0);
      wait_done("f1_done");
      check("f1_busy_at_done", {31'd0, busy_o}, 32'd0);
      check("f1_cs_at_done",   {31'd0, cs_o},   32'd1);
      check("f1_mosi_seq", {16'd0, mosi_cap}, 32'h01A5);
      check("f1_cs_len",   cs_low_tot - snap_cs, 32'd68);
      check("f1_rises",    rise_tot - snap_rise, 32'd16);
      check("f1_rx",       {24'd0, rx_data_o}, 32'hA5);
      @(negedge clk_i);
      check("f1_done_one", {31'd0, done_o}, 32'd0);
      check("f1_busy_after", {31'd0, busy_o}, 32'd0);
      check("f1_done_count", done_tot - snap_done, 32'd1);

      // Frame 2: MISO sends 0x00 then 0x3C
      miso_pat  = 16'h003C;
      tx_cmd_i  = 8'h12;
      tx_data_i = 8'h34;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i   = 1'b0;
      wait_done("f2_done");
      check("f2_rx", {24'd0, rx_data_o}, 32'h3C);
      check("f2_mosi_seq", {16'd0, mosi_cap}, 32'h1234);

      // Frame 3: second start 10 cycles in with cmd 0xFF must be ignored
      repeat (3) @(negedge clk_i);
      miso_pat  = 16'h00C3;
      tx_cmd_i  = 8'h81;
      tx_data_i = 8'h7E;
      snap_cs   = cs_low_tot;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i   = 1'b0;
      repeat (9) @(negedge clk_i);
      tx_cmd_i  = 8'hFF;
      tx_data_i = 8'h00;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i   = 1'b0;
      check("f3_busy_mid", {31'd0, busy_o}, 32'd1);
      check("f3_rx_held",  {24'd0, rx_data_o}, 32'h3C);
      wait_done("f3_done");
      check("f3_mosi_seq", {16'd0, mosi_cap}, 32'h817E);
      check("f3_cs_len",   cs_low_tot - snap_cs, 32'd68);
      check("f3_rx",       {24'd0, rx_data_o}, 32'hC3);
      repeat (5) @(negedge clk_i);
      check("f3_no_queue_cs",   {31'd0, cs_o},   32'd1);
      check("f3_no_queue_busy", {31'd0, busy_o}, 32'd0);

      // Frames 4/5: start held through done, back-to-back frames
      tx_cmd_i  = 8'hC0;
      tx_data_i = 8'h03;
      snap_done = done_tot;
      start_i   = 1'b1;
      wait_done("f4_done1");
      check("f4_gap_cs_hi", {31'd0, cs_o}, 32'd1);
      @(negedge clk_i);
      check("f4_restart_cs",   {31'd0, cs_o},   32'd0);
      check("f4_restart_busy", {31'd0, busy_o}, 32'd1);
      start_i   = 1'b0;
      wait_done("f4_done2");
      check("f4_mosi_seq",   {16'd0, mosi_cap}, 32'hC003);
      check("f4_done_count", done_tot - snap_done, 32'd2);
      check("f4_rx",         {24'd0, rx_data_o}, 32'hC3);

      // Frame 6: reset at the 7th sclk rise aborts the frame
      repeat (3) @(negedge clk_i);
      tx_cmd_i  = 8'hFF;
      tx_data_i = 8'hFF;
      start_i   = 1'b1;
      @(negedge clk_i);
      start_i   = 1'b0;
      snap_rise = rise_tot;
      n = 0;
      while ((rise_tot - snap_rise) < 7 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("f6_reach_rise7", rise_tot - snap_rise, 32'd7);
      check("f6_sclk_hi_pre", {31'd0, sclk_o}, 32'd1);
      check("f6_mosi_hi_pre", {31'd0, mosi_o}, 32'd1);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      snap_done = done_tot;
      check("f6_cs",   {31'd0, cs_o},   32'd1);
      check("f6_sclk", {31'd0, sclk_o}, 32'd0);
      check("f6_mosi", {31'd0, mosi_o}, 32'd0);
      check("f6_busy", {31'd0, busy_o}, 32'd0);
      check("f6_rx",   {24'd0, rx_data_o}, 32'd0);
      repeat (100) @(negedge clk_i);
      check("f6_no_done", done_tot - snap_done, 32'd0);
      check("f6_idle_cs", {31'd0, cs_o}, 32'd1);

`ifdef SPI_HOST_MASTER_LOOPBACK_EN
      // Loopback: miso tied high, rx must return tx_data
      miso_pat   = 16'hFFFF;
      loopback_i = 1'b1;
      tx_cmd_i   = 8'h00;
      tx_data_i  = 8'h5A;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
      loopback_i = 1'b0;
      wait_done("lb_done");
      check("lb_rx", {24'd0, rx_data_o}, 32'h5A);
`endif

      check("sclk_while_cs_hi", glitch_tot, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
